fir_band_sequencer: RTL

Controller that sequences the four-band FIR filter bank (delta, theta, alpha, beta) on `clk_fast`. It accepts one input sample at a time through a valid/ready handshake and issues it to the bank with a one-cycle enable. It then collects the four per-band results as their `*_avl` strobes arrive and serialises them, tagged by band, onto one shared output channel. It sits between the sample source and the filter bank, and owns the bank's `en`/`clr` inputs.

---
 rtl/fir_band_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fir_band_sequencer.sv
// Sequences one sample through the four-band FIR bank, then serialises the band results in band order.
// Optional WAIT timeout enabled by defining FIR_SEQ_TIMEOUT_EN.
module fir_band_sequencer #(
  parameter int DATA_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_fast,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [DATA_W-1:0] bank_in,
  output logic              bank_en,
  output logic              bank_clr,
  input  logic [DATA_W-1:0] delta_in,
  input  logic [DATA_W-1:0] theta_in,
  input  logic [DATA_W-1:0] alpha_in,
  input  logic [DATA_W-1:0] beta_in,
  input  logic              delta_avl,
  input  logic              theta_avl,
  input  logic              alpha_avl,
  input  logic              beta_avl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_band,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_DRAIN, S_CLEAR} state_t;

  state_t                   state_q;
  logic [DATA_W-1:0]        bank_in_q;
  logic                     bank_en_q, bank_clr_q, out_valid_q, busy_q;
  logic [DATA_W-1:0]        out_data_q;
  logic [1:0]               out_band_q;
  logic [3:0]               flg_q, sent_q;
  logic [3:0][DATA_W-1:0]   cap_q;

  logic [3:0]               avl, new_cap, flg_d, sel, rem;
  logic [3:0][DATA_W-1:0]   din, cap_d;
  logic                     all_in, to_drain;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    lowest = 2'd3;
    for (int i = 3; i >= 0; i--)
      if (v[i]) lowest = 2'(i);
  endfunction

  assign avl = {beta_avl, alpha_avl, theta_avl, delta_avl};
  assign din = {beta_in, alpha_in, theta_in, delta_in};

  // Only the first strobe per band is kept; later repeats are masked by the flag.
  assign new_cap = (state_q == S_LOAD || state_q == S_WAIT) ? (avl & ~flg_q) : 4'b0;
  assign flg_d   = flg_q | new_cap;
  assign all_in  = &flg_d;

  always_comb begin
    cap_d = cap_q;
    for (int i = 0; i < 4; i++)
      if (new_cap[i]) cap_d[i] = din[i];
  end

  assign sel = 4'b0001 << out_band_q;
  assign rem = flg_q & ~(sent_q | sel);

`ifdef FIR_SEQ_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       terr_q;
  logic       tmo;
  assign tmo         = (cnt_q == TIMEOUT[7:0]) && !all_in;
  assign to_drain    = (state_q == S_WAIT) && (all_in || (tmo && |flg_d));
  assign timeout_err = terr_q;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT[0];
  assign to_drain       = (state_q == S_WAIT) && all_in;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bank_in_q   <= '0;
      bank_en_q   <= 1'b0;
      bank_clr_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_band_q  <= 2'd0;
      busy_q      <= 1'b0;
      flg_q       <= 4'b0;
      sent_q      <= 4'b0;
      cap_q       <= '0;
`ifdef FIR_SEQ_TIMEOUT_EN
      cnt_q       <= 8'd0;
      terr_q      <= 1'b0;
`endif
    end else begin
      bank_en_q  <= 1'b0;
      bank_clr_q <= 1'b0;
      if (clr) begin
        state_q     <= S_CLEAR;
        bank_clr_q  <= 1'b1;
        busy_q      <= 1'b1;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_band_q  <= 2'd0;
        flg_q       <= 4'b0;
        sent_q      <= 4'b0;
        cap_q       <= '0;
`ifdef FIR_SEQ_TIMEOUT_EN
        terr_q      <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_IDLE: if (sample_valid) begin
            bank_in_q <= sample_in;
            bank_en_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
          S_LOAD: begin
            flg_q   <= flg_d;
            cap_q   <= cap_d;
            state_q <= S_WAIT;
`ifdef FIR_SEQ_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
          end
          S_WAIT: begin
            flg_q <= flg_d;
            cap_q <= cap_d;
            if (to_drain) begin
              state_q     <= S_DRAIN;
              out_valid_q <= 1'b1;
              out_band_q  <= lowest(flg_d);
              out_data_q  <= cap_d[lowest(flg_d)];
              sent_q      <= 4'b0;
            end
`ifdef FIR_SEQ_TIMEOUT_EN
            if (tmo) terr_q <= 1'b1;
            if (tmo && !(|flg_d)) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (!tmo) begin
              cnt_q <= cnt_q + 8'd1;
            end
`endif
          end
          S_DRAIN: if (out_ready) begin
            sent_q <= sent_q | sel;
            if (rem == 4'b0) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              flg_q       <= 4'b0;
              sent_q      <= 4'b0;
            end else begin
              out_band_q <= lowest(rem);
              out_data_q <= cap_q[lowest(rem)];
            end
          end
          S_CLEAR: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sample_ready = (state_q == S_IDLE) && !rst;
  assign bank_in      = bank_in_q;
  assign bank_en      = bank_en_q;
  assign bank_clr     = bank_clr_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_band     = out_band_q;
  assign busy         = busy_q;

endmodule
